// File: rtl/change_dispenser.sv
// Purpose : coin change dispenser. A request for Amount (50-won units) is paid
//           out greedily, largest denomination first, one hopper-acknowledged
//           coin at a time, from four 6-bit coin stocks that can be refilled.
// Latency : Req sampled at edge N -> Busy after N+1, first Return_x after N+2;
//           Amount=0 -> Done after N+2. Each coin waits for HopperAck
//           (ACK_TIMEOUT cycles max).
// Backpressure: Req is ignored while Busy; the hopper stalls payout by
//               withholding HopperAck.
// Ports   : CLK/RST (async, active-high); Req + Amount start a payout;
//           HopperAck confirms an ejected coin; Refill* add one coin each;
//           Return* eject commands (one-hot or zero); Busy/Done/Short/Fault
//           status; Remaining = amount still owed.
module change_dispenser #(
  parameter int unsigned INIT_COUNT  = 10,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Req,
  input  logic [6:0] Amount,
  input  logic       HopperAck,
  input  logic       Refill50,
  input  logic       Refill100,
  input  logic       Refill500,
  input  logic       Refill1000,
  output logic       Return50,
  output logic       Return100,
  output logic       Return500,
  output logic       Return1000,
  output logic       Busy,
  output logic       Done,
  output logic       Short,
  output logic       Fault,
  output logic [6:0] Remaining
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Denomination index: 0=50, 1=100, 2=500, 3=1000 won.
  function automatic logic [6:0] coin_val(input logic [1:0] idx);
    case (idx)
      2'd0:    coin_val = 7'd1;
      2'd1:    coin_val = 7'd2;
      2'd2:    coin_val = 7'd10;
      default: coin_val = 7'd20;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [6:0]  rem_q, rem_d;
  logic [5:0]  cnt_q [4];
  logic [5:0]  cnt_d [4];
  logic [3:0]  tmo_q, tmo_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  ret_q, ret_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        short_q, short_d;
  logic        fault_q, fault_d;

  logic [3:0]  refill;
  logic [3:0]  dec;
  logic        pick_vld;
  logic [1:0]  pick_idx;

  assign refill = {Refill1000, Refill500, Refill100, Refill50};

  // Ascending scan: the last qualifying denomination wins, i.e. the largest.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] != 6'd0 && coin_val(2'(i)) <= rem_q) begin
        pick_vld = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    ret_d   = ret_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    short_d = short_q;
    fault_d = fault_q;
    dec     = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          state_d = S_SELECT;
          rem_d   = Amount;
          short_d = 1'b0;
          fault_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_SELECT: begin
        if (rem_q == 7'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (pick_vld) begin
          state_d = S_DISPENSE;
          sel_d   = pick_idx;
          tmo_d   = 4'd0;
          ret_d   = 4'b0001 << pick_idx;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          short_d = 1'b1;
        end
      end

      S_DISPENSE: begin
        if (HopperAck) begin
          state_d    = S_SELECT;
          rem_d      = rem_q - coin_val(sel_q);
          dec[sel_q] = 1'b1;
          ret_d      = 4'b0000;
        end else if (tmo_q == 4'(ACK_TIMEOUT - 1)) begin
          // Timed out: the coin is not counted as paid.
          state_d = S_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          ret_d   = 4'b0000;
          tmo_d   = tmo_q + 4'd1;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      default: begin  // S_DONE
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Coin stocks: refill saturates at 63; refill and payout of the same
  // denomination in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (refill[i] && !dec[i]) begin
        if (cnt_q[i] != 6'd63) cnt_d[i] = cnt_q[i] + 6'd1;
      end else if (!refill[i] && dec[i]) begin
        cnt_d[i] = cnt_q[i] - 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rem_q   <= 7'd0;
      tmo_q   <= 4'd0;
      sel_q   <= 2'd0;
      ret_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      fault_q <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 6'(INIT_COUNT);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      short_q <= short_d;
      fault_q <= fault_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign Return50   = ret_q[0];
  assign Return100  = ret_q[1];
  assign Return500  = ret_q[2];
  assign Return1000 = ret_q[3];
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Short      = short_q;
  assign Fault      = fault_q;
  assign Remaining  = rem_q;

endmodule
